// File: rtl/trace_capture.sv
// Instruction trace capture: records {pc, instr} pairs into a FIFO while armed.
// Capture stops on an explicit stop pulse or when the halt instruction is seen.
module trace_capture #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [31:0] HALT_INSTR = 32'h1000FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic                     capturing,
    output logic                     halted,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   entry_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;

    state_t         state, state_next;
    logic           push, clear_stats;
    logic           full, pop, wr_en, drop;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [63:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        push        = 1'b0;
        clear_stats = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = CAPTURE;
                    clear_stats = 1'b1;
                end
            end
            CAPTURE: begin
                // stop takes priority over a halt match in the same cycle
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    push = 1'b1;
                    if (instr_in == HALT_INSTR) state_next = HALTED;
                end
            end
            HALTED: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next  = CAPTURE;
                    clear_stats = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign capturing = (state == CAPTURE);
    assign halted    = (state == HALTED);

    assign out_valid = (entry_count != '0);
    assign full      = (entry_count == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // a pop frees the slot the full-FIFO push lands in on the same edge
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {pc_in, instr_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   entry_count <= entry_count + CW'(1);
                2'b01:   entry_count <= entry_count - CW'(1);
                default: entry_count <= entry_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 16'd1;
        end
    end

endmodule
